// File: rtl/expansion_shiftreg_slave.sv
// Target end of the expansion shift-register link. It synchronises the
// asynchronous link pins, captures WIDTH-bit frames from the master into
// data_out, and shifts data_in back to the master MSB first in the same frame.
module expansion_shiftreg_slave #(
  parameter int unsigned WIDTH   = 8,
  parameter int unsigned TIMEOUT = 1000000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             SHIFT_CLK,
  input  logic             SHIFT_LOAD,
  input  logic             SHIFT_IN,
  output logic             SHIFT_OUT,
  output logic [WIDTH-1:0] data_out,
  input  logic [WIDTH-1:0] data_in,
  output logic             frame_valid,
  output logic             frame_error,
  output logic             link_ok
);

  localparam int unsigned CNT_W = $clog2(WIDTH + 1);
  localparam int unsigned WD_W  = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {ST_IDLE, ST_SHIFT, ST_LOAD} state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic               r_sclk_meta, r_sclk_sync, r_sclk_hist;
  logic               r_load_meta, r_load_sync, r_load_hist;
  logic               r_sin_meta, r_sin_sync;
  logic [WIDTH-1:0]   r_rx_sr, r_tx_sr, r_data_out;
  logic [CNT_W-1:0]   r_bitcnt;
  logic [WD_W-1:0]    r_wdog;
  logic               r_overrun, r_shift_out, r_frame_valid, r_frame_error, r_link_ok;
  logic               w_clk_rise, w_clk_fall, w_load_rise, w_load_fall;
  logic               w_wdog_expire, w_full;
  logic               w_commit, w_valid, w_error, w_shift, w_ovr_set;

  assign w_clk_rise    = r_sclk_sync & ~r_sclk_hist;
  assign w_clk_fall    = ~r_sclk_sync & r_sclk_hist;
  assign w_load_rise   = r_load_sync & ~r_load_hist;
  assign w_load_fall   = ~r_load_sync & r_load_hist;
  assign w_full        = (r_bitcnt == CNT_W'(WIDTH));
  // Fires once, on the cycle the counter would step onto TIMEOUT.
  assign w_wdog_expire = ~(w_clk_rise | w_clk_fall) && (r_wdog == WD_W'(TIMEOUT - 1));

  assign SHIFT_OUT   = r_shift_out;
  assign data_out    = r_data_out;
  assign frame_valid = r_frame_valid;
  assign frame_error = r_frame_error;
  assign link_ok     = r_link_ok;

  // Two-flop synchronisers plus history flops for edge detection; LOAD idles high.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sclk_meta <= 1'b0;
      r_sclk_sync <= 1'b0;
      r_sclk_hist <= 1'b0;
      r_load_meta <= 1'b1;
      r_load_sync <= 1'b1;
      r_load_hist <= 1'b1;
      r_sin_meta  <= 1'b0;
      r_sin_sync  <= 1'b0;
    end else begin
      r_sclk_meta <= SHIFT_CLK;
      r_sclk_sync <= r_sclk_meta;
      r_sclk_hist <= r_sclk_sync;
      r_load_meta <= SHIFT_LOAD;
      r_load_sync <= r_load_meta;
      r_load_hist <= r_load_sync;
      r_sin_meta  <= SHIFT_IN;
      r_sin_sync  <= r_sin_meta;
    end
  end

  // Watchdog: cleared by any link clock edge, saturates at TIMEOUT.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wdog <= '0;
    end else if (w_clk_rise || w_clk_fall) begin
      r_wdog <= '0;
    end else if (r_wdog != WD_W'(TIMEOUT)) begin
      r_wdog <= r_wdog + WD_W'(1);
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_nxt;
  end

  // Next state and datapath controls; the if-chain encodes event priority.
  always_comb begin
    w_state_nxt = r_state;
    w_commit    = 1'b0;
    w_valid     = 1'b0;
    w_error     = 1'b0;
    w_shift     = 1'b0;
    w_ovr_set   = 1'b0;
    if (w_wdog_expire) begin
      w_state_nxt = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_load_rise) begin
            w_commit    = 1'b1;
            w_state_nxt = ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          if (w_load_rise) begin
            w_state_nxt = ST_SHIFT;
          end else if (w_load_fall) begin
            w_state_nxt = ST_LOAD;
          end else if (w_clk_fall) begin
            if (!w_full) w_shift   = 1'b1;
            else         w_ovr_set = 1'b1;
          end
        end
        ST_LOAD: begin
          if (w_load_rise) begin
            w_commit    = 1'b1;
            w_valid     = w_full && !r_overrun;
            w_error     = !(w_full && !r_overrun);
            w_state_nxt = ST_SHIFT;
          end
        end
        default: w_state_nxt = ST_IDLE;
      endcase
    end
  end

  // Shift registers, bit counter, frame commit and status outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rx_sr       <= '0;
      r_tx_sr       <= '0;
      r_data_out    <= '0;
      r_bitcnt      <= '0;
      r_overrun     <= 1'b0;
      r_shift_out   <= 1'b0;
      r_frame_valid <= 1'b0;
      r_frame_error <= 1'b0;
      r_link_ok     <= 1'b0;
    end else begin
      r_frame_valid <= w_valid;
      r_frame_error <= w_error;
      if (w_commit) begin
        r_tx_sr     <= data_in;
        r_bitcnt    <= '0;
        r_overrun   <= 1'b0;
        r_shift_out <= data_in[WIDTH-1];
      end else if (w_shift) begin
        r_rx_sr     <= {r_rx_sr[WIDTH-2:0], r_sin_sync};
        r_tx_sr     <= r_tx_sr << 1;
        r_bitcnt    <= r_bitcnt + CNT_W'(1);
        r_shift_out <= r_tx_sr[WIDTH-2];
      end else if (w_ovr_set) begin
        r_overrun   <= 1'b1;
      end
      if (w_valid) begin
        r_data_out <= r_rx_sr;
        r_link_ok  <= 1'b1;
      end else if (w_wdog_expire) begin
        r_link_ok  <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_expansion_shiftreg_slave.sv
// Bench for expansion_shiftreg_slave: a master model drives frames on the
// asynchronous pins and a frame-level model predicts commits and returned words.
module tb_expansion_shiftreg_slave;

  localparam int unsigned W  = 8;
  localparam int unsigned TO = 200;
  localparam int unsigned H  = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         SHIFT_CLK, SHIFT_LOAD, SHIFT_IN, SHIFT_OUT;
  logic [W-1:0] data_out, data_in;
  logic         frame_valid, frame_error, link_ok;

  int checks = 0;
  int errors = 0;
  int nvalid = 0;
  int nerror = 0;
  bit both_seen = 1'b0;

  bit           m_armed = 1'b0;
  bit           m_link  = 1'b0;
  logic [W-1:0] m_data_out = '0;
  logic [W-1:0] m_tx = '0;

  expansion_shiftreg_slave #(.WIDTH(W), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .SHIFT_CLK(SHIFT_CLK), .SHIFT_LOAD(SHIFT_LOAD),
    .SHIFT_IN(SHIFT_IN), .SHIFT_OUT(SHIFT_OUT), .data_out(data_out),
    .data_in(data_in), .frame_valid(frame_valid), .frame_error(frame_error),
    .link_ok(link_ok)
  );

  always #5 clk = ~clk;

  // Count high cycles of each pulse output, so a stretched pulse shows as >1.
  always @(negedge clk) begin
    if (frame_valid) nvalid++;
    if (frame_error) nerror++;
    if (frame_valid && frame_error) both_seen = 1'b1;
  end

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_data_out"}, 64'(data_out), 64'(0));
    check({tag, "_shift_out"}, 64'(SHIFT_OUT), 64'(0));
    check({tag, "_valid"}, 64'(frame_valid), 64'(0));
    check({tag, "_error"}, 64'(frame_error), 64'(0));
    check({tag, "_link_ok"}, 64'(link_ok), 64'(0));
  endtask

  task automatic send_bit(input logic b, output logic sampled);
    SHIFT_CLK = 1'b1;
    sampled   = SHIFT_OUT;
    SHIFT_IN  = b;
    wait_clk(H);
    SHIFT_CLK = 1'b0;
    wait_clk(H);
  endtask

  // One master frame: nbits data clocks, then a LOAD-low clock, then LOAD high.
  // nbits == 0 is a bare LOAD sequence, as used to arm the link.
  task automatic do_frame(input string tag, input logic [W-1:0] word, input int nbits, input bit coinc);
    logic [W-1:0] got;
    logic         s;
    int           v0, e0;
    bit           armed_before, exp_v, exp_e;
    logic [W-1:0] tx_before;
    got = '0;
    v0 = nvalid;
    e0 = nerror;
    armed_before = m_armed;
    tx_before = m_tx;
    for (int i = 0; i < nbits; i++) begin
      send_bit((i < int'(W)) ? word[W-1-i] : 1'b0, s);
      if (i < int'(W)) got = {got[W-2:0], s};
    end
    SHIFT_LOAD = 1'b0;
    wait_clk(H);
    SHIFT_CLK = 1'b1;
    wait_clk(H);
    SHIFT_CLK = 1'b0;
    if (coinc) begin
      SHIFT_LOAD = 1'b1;
    end else begin
      wait_clk(H);
      SHIFT_LOAD = 1'b1;
    end
    wait_clk(12);
    exp_v = 1'b0;
    exp_e = 1'b0;
    if (!m_armed) begin
      m_armed = 1'b1;
    end else if (nbits == int'(W)) begin
      exp_v = 1'b1;
      m_data_out = word;
      m_link = 1'b1;
    end else begin
      exp_e = 1'b1;
    end
    m_tx = data_in;
    check({tag, "_valid_cycles"}, 64'(nvalid - v0), 64'(exp_v));
    check({tag, "_error_cycles"}, 64'(nerror - e0), 64'(exp_e));
    check({tag, "_data_out"}, 64'(data_out), 64'(m_data_out));
    check({tag, "_link_ok"}, 64'(link_ok), 64'(m_link));
    if (armed_before && nbits >= int'(W))
      check({tag, "_returned"}, 64'(got), 64'(tx_before));
  endtask

  initial begin
    logic s;
    int   r, n;
    bit   c;
    rst = 1'b1;
    SHIFT_CLK = 1'b0;
    SHIFT_LOAD = 1'b1;
    SHIFT_IN = 1'b0;
    data_in = '0;
    wait_clk(4);
    check_reset_outputs("reset");
    rst = 1'b0;
    wait_clk(4);

    data_in = 8'hA5;
    do_frame("arm0", 8'h00, 0, 1'b0);
    do_frame("basic", 8'h3C, 8, 1'b0);
    data_in = 8'h11;
    do_frame("b2b_01", 8'h01, 8, 1'b0);
    data_in = 8'h22;
    do_frame("b2b_80", 8'h80, 8, 1'b0);
    data_in = 8'h33;
    do_frame("b2b_ff", 8'hFF, 8, 1'b0);
    data_in = 8'h44;
    do_frame("short", 8'h12, 7, 1'b0);
    do_frame("long", 8'h34, 9, 1'b0);
    do_frame("after_long", 8'h56, 8, 1'b0);

    wait_clk(TO + 10);
    m_link = 1'b0;
    m_armed = 1'b0;
    check("watchdog_link_ok", 64'(link_ok), 64'(m_link));
    data_in = 8'h99;
    do_frame("wd_arm", 8'h00, 0, 1'b0);
    do_frame("wd_good", 8'h77, 8, 1'b0);

    for (int i = 0; i < 4; i++) send_bit(i[0], s);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check_reset_outputs("mid_reset");
    wait_clk(2);
    rst = 1'b0;
    m_armed = 1'b0;
    m_link = 1'b0;
    m_data_out = '0;
    wait_clk(4);
    data_in = 8'hC7;
    do_frame("rst_arm", 8'h00, 0, 1'b0);
    do_frame("rst_5a", 8'h5A, 8, 1'b0);

    data_in = 8'h6B;
    do_frame("coinc", 8'hC3, 8, 1'b1);
    do_frame("after_coinc", 8'h96, 8, 1'b0);

    for (int i = 0; i < 16; i++) begin
      r = int'($urandom_range(0, 9));
      n = (r == 0) ? 7 : (r == 1) ? 9 : 8;
      c = ($urandom_range(0, 3) == 0);
      data_in = W'($urandom);
      do_frame($sformatf("rand%0d", i), W'($urandom), n, c);
    end

    check("never_both_pulses", 64'(both_seen), 64'(0));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/expansion_shiftreg_slave.md
# expansion_shiftreg_slave

Target end of the expansion shift-register link. The block sits on a satellite FPGA and accepts SHIFT_CLK, SHIFT_LOAD and serial data from the expansion master. It captures each WIDTH-bit frame into a parallel output and, in the same frame, shifts a parallel input word back to the master, MSB first. All link pins are asynchronous to `clk`, so they are synchronised and edge-detected internally.

## Interface
- `WIDTH`, default 8: frame length in bits, legal range 2..64.
- `TIMEOUT`, default 1000000: number of `clk` cycles without any SHIFT_CLK edge before the link is declared down.
- `clk`  in  1: system clock, at least 8x the SHIFT_CLK frequency.
- `rst`  in  1: synchronous, active-high reset.
- `SHIFT_CLK`  in  1: link clock from the master; asynchronous.
- `SHIFT_LOAD`  in  1: frame strobe from the master, active low; asynchronous.
- `SHIFT_IN`  in  1: serial data from the master (the master's SHIFT_OUT); asynchronous.
- `SHIFT_OUT`  out  1: serial data to the master (the master's SHIFT_IN).
- `data_out`  out  WIDTH: last good frame received from the master.
- `data_in`  in  WIDTH: word returned to the master; sampled at each frame start.
- `frame_valid`  out  1: one-cycle pulse when `data_out` updates.
- `frame_error`  out  1: one-cycle pulse when a frame is discarded.
- `link_ok`  out  1: high after a good frame; cleared by the watchdog.

## Operation
- **Synchroniser.** `SHIFT_CLK`, `SHIFT_LOAD` and `SHIFT_IN` each pass through 2 flops, plus one history flop for edge detection.
- **Edge events.**
  - `clk_rise`: synchronised SHIFT_CLK 0→1.
  - `clk_fall`: synchronised SHIFT_CLK 1→0.
  - `load_fall`: synchronised SHIFT_LOAD 1→0.
  - `load_rise`: synchronised SHIFT_LOAD 0→1.
- **Link protocol.**
  - The master changes its data on SHIFT_CLK rising edges and samples our SHIFT_OUT on rising edges.
  - We sample SHIFT_IN on `clk_fall` and advance SHIFT_OUT on `clk_fall`.
  - One frame is WIDTH data clocks, then one clock with SHIFT_LOAD low, then SHIFT_LOAD high.
- **State machine:** IDLE, SHIFT, LOAD.
  - **IDLE** is entered on reset or watchdog expiry. All clock events are ignored. `load_rise` → SHIFT.
  - **SHIFT:**
    - On `clk_fall` with `bitcnt < WIDTH`: `rx_sr <= {rx_sr[WIDTH-2:0], SHIFT_IN_sync}`, `tx_sr <= tx_sr << 1`, `bitcnt++`.
    - On `clk_fall` with `bitcnt == WIDTH`: set sticky `overrun`; nothing is shifted.
    - `load_fall` → LOAD.
  - **LOAD:** all clock edges are ignored. `load_rise` → frame commit, then SHIFT.
- **Frame commit on `load_rise`** (from LOAD or IDLE):
  - Good frame: coming from LOAD with `bitcnt == WIDTH` and `!overrun`. Then `data_out <= rx_sr`, `frame_valid` pulses and `link_ok <= 1`.
  - Otherwise, coming from LOAD: `frame_error` pulses and `data_out` is held.
  - Coming from IDLE: no pulse at all.
  - In every case: `tx_sr <= data_in`, `bitcnt <= 0`, `overrun <= 0`.
- **SHIFT_OUT** is `tx_sr[WIDTH-1]`, registered. The MSB of `data_in` is therefore on the pin from the cycle after `load_rise`.
- **Event priority in a single cycle:** `load_rise` > `load_fall` > `clk_fall` > `clk_rise`. Lower-priority events in that cycle are dropped.
- **Watchdog.**
  - The counter resets on any `clk_rise` or `clk_fall`.
  - On reaching TIMEOUT: `link_ok <= 0` and state → IDLE. A partial frame is discarded with no `frame_error`.
  - The counter saturates at TIMEOUT.
- `bitcnt` width is `$clog2(WIDTH+1)`. It saturates at WIDTH and never wraps.

## Timing
- **Reset values:** `SHIFT_OUT` 0, `data_out` 0, `frame_valid` 0, `frame_error` 0, `link_ok` 0, state IDLE, `bitcnt` 0, `tx_sr` 0, `rx_sr` 0, watchdog 0.
- **Pin-to-event latency:** 3 `clk` cycles (2 sync flops + history flop compare).
- **SHIFT_OUT update:** registered on the event cycle, so it appears on the pin 4 `clk` cycles after the SHIFT_CLK falling pin edge. It must be stable before the next rising edge, which the ≥8x ratio guarantees.
- **Frame commit:** `data_out`, `frame_valid`, `frame_error` and `link_ok` all update on the cycle after `load_rise`, i.e. 4 cycles after the SHIFT_LOAD pin rises.
- **Pulse width:** `frame_valid` and `frame_error` are exactly 1 `clk` wide and never both high.
- **Reset mid-frame:** the block returns to IDLE. The first `load_rise` after reset only arms the block. The next complete frame commits normally.

## Test plan
- **Basic frame:** WIDTH=8, `data_in`=0xA5; master model clocks out 0x3C and then does LOAD low/high. → `data_out`=0x3C with one `frame_valid` pulse. The bits the model sampled on the following frame equal 0xA5, MSB first.
- **Back-to-back frames:** 0x01, 0x80, 0xFF with `data_in` changing between frames. → Three `frame_valid` pulses, `data_out` following in order, and each returned word equal to `data_in` as sampled at the preceding `load_rise`.
- **Short frame:** 7 clocks then LOAD. → One `frame_error` pulse; `data_out` keeps its previous value. Long frame: 9 clocks then LOAD. → One `frame_error` pulse (overrun); the next 8-clock frame commits normally.
- **Watchdog:** after a good frame, SHIFT_CLK is stopped for TIMEOUT+10 cycles. → `link_ok` falls. The first LOAD afterwards gives no pulse; the next good frame raises `link_ok`.
- **Reset mid-frame:** assert `rst` after 4 bits. → All outputs return to reset values next cycle; one arming LOAD, then a frame of 0x5A → `data_out`=0x5A.
- **Coincident events:** SHIFT_LOAD rising and SHIFT_CLK falling in the same synchronised cycle. → The commit happens; the clock edge is dropped and `bitcnt`=0 afterwards.
